// File: rtl/fifo_cascade_ctrl_pkg.sv
// Shared definitions for the two-stage FIFO cascade sequencer.
//  DEPTH_DEFAULT : entries per stage (power of two)
//  state_t       : sequencer states RUN / FLUSH / DONE
//  cnt_width()   : per-stage counter width, wide enough to hold 0..depth inclusive
package fifo_cascade_ctrl_pkg;

  localparam int DEPTH_DEFAULT = 2048;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_cascade_ctrl_if.sv
// Bus bundle between the cascade sequencer and its user / the two stage FIFOs.
//  User side : w_en, r_en, flush requests; full, empty, avail, occupancy status;
//              overflow/underflow/flush_done pulses and the sticky flag_err.
//  Stage side: e1/f1, e2/f2 flags from the stages; w1/r1, w2/r2 enables to them.
//  master : the environment (user logic plus stage flags)
//  slave  : the sequencer itself
interface fifo_cascade_ctrl_if
  import fifo_cascade_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) ();

  localparam int CW = cnt_width(DEPTH);

  logic          w_en;
  logic          r_en;
  logic          flush;
  logic          e1;
  logic          f1;
  logic          e2;
  logic          f2;
  logic          w1;
  logic          r1;
  logic          w2;
  logic          r2;
  logic          full;
  logic          empty;
  logic          avail;
  logic [CW:0]   occupancy;
  logic          overflow;
  logic          underflow;
  logic          flush_done;
  logic          flag_err;

  modport master (
    output w_en, r_en, flush, e1, f1, e2, f2,
    input  w1, r1, w2, r2, full, empty, avail, occupancy,
           overflow, underflow, flush_done, flag_err
  );

  modport slave (
    input  w_en, r_en, flush, e1, f1, e2, f2,
    output w1, r1, w2, r2, full, empty, avail, occupancy,
           overflow, underflow, flush_done, flag_err
  );

endinterface

// File: rtl/fifo_occ_counter.sv
// Bounded up/down occupancy counter for one FIFO stage.
//  clk, rst : clock, asynchronous active-high reset
//  inc, dec : entry written / entry read this cycle
//  count    : entries currently held, 0..DEPTH
//  is_zero  : count == 0
//  is_max   : count == DEPTH
module fifo_occ_counter
  import fifo_cascade_ctrl_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          is_zero,
  output logic          is_max
);

  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  assign is_zero = (count == '0);
  assign is_max  = (count == MAX);

  // Simultaneous inc and dec cancel; the bounds are a safety net behind the gated enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !is_max) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !is_zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fifo_cascade_ctrl.sv
// Sequencer for a stage1 -> stage2 FIFO cascade holding 2*DEPTH entries.
// Writes go into stage1, reads come out of stage2, and words are moved from
// stage1 to stage2 in the background. Enables come from internal occupancy
// counters; the stage flags are only cross-checked into flag_err.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : fifo_cascade_ctrl_if slave modport (requests, stage flags,
//             stage enables, status and pulses)
module fifo_cascade_ctrl
  import fifo_cascade_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  fifo_cascade_ctrl_if.slave bus
);

  localparam int          CW      = cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic          zero1;
  logic          max1;
  logic          zero2;
  logic          max2;
  logic          xfer;
  logic          xfer_q;
  logic          w1;
  logic          r1;
  logic          r2;
  logic          room2;
  logic          flag_err_q;

  fifo_occ_counter #(.DEPTH(DEPTH)) u_cnt1 (
    .clk     (clk),
    .rst     (rst),
    .inc     (w1),
    .dec     (r1),
    .count   (cnt1),
    .is_zero (zero1),
    .is_max  (max1)
  );

  fifo_occ_counter #(.DEPTH(DEPTH)) u_cnt2 (
    .clk     (clk),
    .rst     (rst),
    .inc     (xfer_q),
    .dec     (r2),
    .count   (cnt2),
    .is_zero (zero2),
    .is_max  (max2)
  );

  // A word already read from stage1 still occupies a stage2 slot, so it is counted here.
  assign room2 = ((CW+1)'(cnt2) + (CW+1)'(xfer_q)) < DEPTH_W;

  // Next-state and stage enables. DONE only ever sees empty stages, so it reuses
  // the user-facing enables of RUN without starting a transfer.
  always_comb begin
    state_nx = state;
    w1       = 1'b0;
    r1       = 1'b0;
    r2       = 1'b0;
    xfer     = 1'b0;
    unique case (state)
      RUN: begin
        w1   = bus.w_en && !max1;
        xfer = !zero1 && room2;
        r1   = xfer;
        r2   = bus.r_en && !zero2;
        if (bus.flush) state_nx = FLUSH;
      end
      FLUSH: begin
        r1 = !zero1;
        r2 = !zero2;
        if (zero1 && zero2 && !xfer_q) state_nx = DONE;
      end
      DONE: begin
        w1       = bus.w_en && !max1;
        r2       = bus.r_en && !zero2;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // State, in-flight transfer and sticky flag cross-check. Each flag is compared
  // against the counter value of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      xfer_q     <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      state      <= state_nx;
      xfer_q     <= (state == RUN) && xfer;
      flag_err_q <= flag_err_q ||
                    (bus.f1 != max1)  || (bus.e1 != zero1) ||
                    (bus.f2 != max2)  || (bus.e2 != zero2);
    end
  end

  assign bus.w1         = w1;
  assign bus.r1         = r1;
  assign bus.w2         = xfer_q;
  assign bus.r2         = r2;
  assign bus.full       = max1;
  assign bus.empty      = zero1 && zero2 && !xfer_q;
  assign bus.avail      = !zero2;
  assign bus.occupancy  = (CW+1)'(cnt1) + (CW+1)'(cnt2) + (CW+1)'(xfer_q);
  assign bus.overflow   = bus.w_en && (max1 || (state == FLUSH));
  assign bus.underflow  = bus.r_en && zero2;
  assign bus.flush_done = (state == DONE);
  assign bus.flag_err   = flag_err_q;

endmodule
